// File: rtl/dark_ifetch.sv
// dark_ifetch: instruction fetch unit with credit-based request issue,
// in-order response tracking, redirect flush and a small instruction queue.
//
// Ports:
//   XCLK, XRES               clock, synchronous active-high reset
//   bus_en, bus_addr         fetch request to instruction memory
//   bus_data, bus_valid      in-order response from memory
//   redirect, redirect_pc    flush and restart fetch at a new address
//   inst_valid, inst_ready   head-of-queue handshake with the consumer
//   inst_data, inst_pc       head instruction word and its address
module dark_ifetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned MAX_OUT  = 2
) (
  input  logic        XCLK,
  input  logic        XRES,
  output logic        bus_en,
  output logic [31:0] bus_addr,
  input  logic [31:0] bus_data,
  input  logic        bus_valid,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_data,
  output logic [31:0] inst_pc
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] MAXO_C  = CW'(MAX_OUT);
  localparam logic [31:0]   NOP     = 32'h0000_0013;

  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   resp_pc_q, resp_pc_d;
  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] out_q, out_d;
  logic [CW-1:0] drop_q, drop_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;

  logic [31:0] data_mem [DEPTH];
  logic [31:0] pc_mem   [DEPTH];

  logic        issue;
  logic        resp;
  logic        push;
  logic        pop;
  logic [CW:0] credit;

  // Queue slots already claimed: stored entries plus requests in flight.
  assign credit = {1'b0, count_q} + {1'b0, out_q};

  assign issue = !XRES && !redirect
               && (out_q < MAXO_C)
               && (credit < {1'b0, DEPTH_C});

  // A response with nothing outstanding is not ours; ignore it.
  assign resp = bus_valid && (out_q != '0);
  assign push = resp && (drop_q == '0) && !redirect && !XRES;

  assign inst_valid = !XRES && !redirect && (count_q != '0);
  assign pop        = inst_valid && inst_ready;

  assign bus_en    = issue;
  assign bus_addr  = XRES ? RESET_PC : fetch_pc_q;
  assign inst_data = inst_valid ? data_mem[rd_ptr_q] : NOP;
  assign inst_pc   = inst_valid ? pc_mem[rd_ptr_q] : 32'h0;

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    resp_pc_d  = resp_pc_q;
    count_d    = count_q;
    out_d      = out_q;
    drop_d     = drop_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    if (redirect) begin
      fetch_pc_d = redirect_pc & ~32'h3;
      resp_pc_d  = redirect_pc & ~32'h3;
      count_d    = '0;
      rd_ptr_d   = wr_ptr_q;
      // Everything still in flight is stale, including older drops.
      out_d      = out_q - CW'(resp);
      drop_d     = out_q - CW'(resp);
    end else begin
      if (issue) begin
        fetch_pc_d = fetch_pc_q + 32'd4;
      end
      if (push) begin
        resp_pc_d = resp_pc_q + 32'd4;
        wr_ptr_d  = wr_ptr_q + PW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
      if (resp && (drop_q != '0)) begin
        drop_d = drop_q - CW'(1);
      end
      case ({issue, resp})
        2'b10:   out_d = out_q + CW'(1);
        2'b01:   out_d = out_q - CW'(1);
        default: out_d = out_q;
      endcase
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge XCLK) begin
    if (XRES) begin
      fetch_pc_q <= RESET_PC;
      resp_pc_q  <= RESET_PC;
      count_q    <= '0;
      out_q      <= '0;
      drop_q     <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      resp_pc_q  <= resp_pc_d;
      count_q    <= count_d;
      out_q      <= out_d;
      drop_q     <= drop_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
    end
  end

  // Queue storage needs no reset; count gates every read.
  always_ff @(posedge XCLK) begin
    if (push) begin
      data_mem[wr_ptr_q] <= bus_data;
      pc_mem[wr_ptr_q]   <= resp_pc_q;
    end
  end

endmodule
